serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/serial_compare_ctrl_pkg.sv | 11 +
 rtl/comparator.sv | 17 +
 rtl/pb_edge_sync.sv | 31 +++
 rtl/serial_compare_ctrl.sv | 113 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 135 +++++++++++++
 5 files changed

// File: rtl/serial_compare_ctrl_pkg.sv
// Shared types and widths for the serial magnitude comparator controller.
package serial_compare_ctrl_pkg;
  localparam int OPERAND_W = 8;
  localparam int NIBBLE_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/comparator.sv
// 1-bit magnitude comparator cell, chained MSB first.
// Once the upstream chain has decided (lin or gin), that decision is kept;
// only an undecided (ein) chain looks at this bit pair.
module comparator (
  input  logic a,
  input  logic b,
  input  logic lin,
  input  logic ein,
  input  logic gin,
  output logic lout,
  output logic eout,
  output logic gout
);
  assign lout = lin | (ein & ~a & b);
  assign gout = gin | (ein & a & ~b);
  assign eout = ein & ~(a ^ b);
endmodule

// File: rtl/pb_edge_sync.sv
// Push-button synchronizer and rising-edge detector for one bit.
// A load event appears during the cycle after the 2nd edge following the rise,
// so the consumer writes on the 3rd edge.
module pb_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pb,
  output logic rise
);
  logic       s1, s2, s3;
  // warm counts the first edges after reset; until s3 holds a real post-reset
  // sample, a button held through reset would otherwise look like a rise.
  logic [1:0] warm;

  // two-flop sync, history flop for edge detect, warm-up counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      warm <= 2'd0;
    end else begin
      s1 <= pb;
      s2 <= s1;
      s3 <= s2;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  assign rise = s2 & ~s3 & (warm == 2'd3);
endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial 8-bit comparator: loads operands a/b by nibble, then walks one
// comparator cell from bit 7 down to bit 0 over exactly 8 RUN cycles.
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int PB_SYNC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIBBLE_W-1:0]  y,
  input  logic [3:0]           pb,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 lout,
  output logic                 eout,
  output logic                 gout,
  output logic [OPERAND_W-1:0] a_val,
  output logic [OPERAND_W-1:0] b_val
);
  state_t               state;
  logic [2:0]           idx;
  logic [OPERAND_W-1:0] a, b;
  logic                 lt, eq, gt;
  logic                 c_l, c_e, c_g;
  logic [3:0]           ld;

  // load-event source: synchronized button edges, or raw strobes
  generate
    if (PB_SYNC != 0) begin : g_sync
      for (genvar i = 0; i < 4; i++) begin : g_bit
        pb_edge_sync u_sync (
          .clk  (clk),
          .rst  (rst),
          .pb   (pb[i]),
          .rise (ld[i])
        );
      end
    end else begin : g_bypass
      assign ld = pb;
    end
  endgenerate

  comparator u_cmp (
    .a    (a[idx]),
    .b    (b[idx]),
    .lin  (lt),
    .ein  (eq),
    .gin  (gt),
    .lout (c_l),
    .eout (c_e),
    .gout (c_g)
  );

  // control FSM, operand registers, chain state and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd7;
      a     <= '0;
      b     <= '0;
      lt    <= 1'b0;
      eq    <= 1'b1;
      gt    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      lout  <= 1'b0;
      eout  <= 1'b1;
      gout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // loads land in the same edge as start, so RUN sees updated operands
          if (ld[0]) a[NIBBLE_W-1:0]         <= y;
          if (ld[1]) a[OPERAND_W-1:NIBBLE_W] <= y;
          if (ld[2]) b[NIBBLE_W-1:0]         <= y;
          if (ld[3]) b[OPERAND_W-1:NIBBLE_W] <= y;
          if (start) begin
            state <= RUN;
            idx   <= 3'd7;
            lt    <= 1'b0;
            eq    <= 1'b1;
            gt    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          lt  <= c_l;
          eq  <= c_e;
          gt  <= c_g;
          idx <= idx - 3'd1;
          if (idx == 3'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            lout  <= c_l;
            eout  <= c_e;
            gout  <= c_g;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          idx   <= 3'd7;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign a_val = a;
  assign b_val = b;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench: strobe-mode instance for the compare flow, button-mode
// instance for synchronizer behaviour.
module tb_serial_compare_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] y, pb, y_s, pb_s;
  logic       start;
  logic       start_s;
  logic       busy, done, lout, eout, gout;
  logic       busy_s, done_s, lout_s, eout_s, gout_s;
  logic [7:0] a_val, b_val, a_val_s, b_val_s;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_compare_ctrl #(.PB_SYNC(0)) u_dut (
    .clk(clk), .rst(rst), .y(y), .pb(pb), .start(start),
    .busy(busy), .done(done), .lout(lout), .eout(eout), .gout(gout),
    .a_val(a_val), .b_val(b_val)
  );

  serial_compare_ctrl #(.PB_SYNC(1)) u_dut_s (
    .clk(clk), .rst(rst), .y(y_s), .pb(pb_s), .start(start_s),
    .busy(busy_s), .done(done_s), .lout(lout_s), .eout(eout_s), .gout(gout_s),
    .a_val(a_val_s), .b_val(b_val_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int nib, input logic [3:0] val);
    pb = 4'b0001 << nib;
    y  = val;
    tick();
    pb = 4'b0000;
  endtask

  // start (optionally with a coincident load), optional pb pulse in RUN cycle 2,
  // then check timing and the {l,e,g} result
  task automatic run_cmp(input string tag, input logic [3:0] spb, input logic [3:0] mpb,
                         input logic [3:0] yv, input logic [2:0] lge);
    logic ok;
    start = 1'b1;
    pb    = spb;
    y     = yv;
    tick();                     // E0
    start = 1'b0;
    pb    = 4'b0000;
    ok    = busy & ~done;
    for (int c = 1; c <= 7; c++) begin
      if (c == 2) pb = mpb;
      tick();                   // E1..E7
      pb = 4'b0000;
      ok = ok & busy & ~done;
    end
    chk({tag, "_busy8"}, ok, 1'b1);
    tick();                     // E8
    chk({tag, "_done"}, {busy, done}, 2'b01);
    chk({tag, "_lge"}, {lout, eout, gout}, lge);
    tick();                     // E9
    chk({tag, "_done_end"}, {busy, done}, 2'b00);
  endtask

  initial begin
    logic ok;
    rst = 1'b1; y = 4'h0; pb = 4'h0; start = 1'b0;
    start_s = 1'b0; y_s = 4'hC; pb_s = 4'b0100;   // button held through reset
    tick(); tick();
    chk("rst_ctl", {busy, done}, 2'b00);
    chk("rst_lge", {lout, eout, gout}, 3'b010);
    chk("rst_ops", {a_val, b_val}, 16'h0000);
    rst = 1'b0;
    repeat (10) tick();
    chk("held_pb_no_load", b_val_s, 8'h00);
    pb_s = 4'b0000;

    // equal operands
    load(0, 4'hA); load(1, 4'h5); load(2, 4'hA); load(3, 4'h5);
    chk("ops_5a", {a_val, b_val}, 16'h5A5A);
    run_cmp("eq5a", 4'h0, 4'h0, 4'h0, 3'b010);

    // greater, then less
    load(0, 4'h0); load(1, 4'h8); load(2, 4'hF); load(3, 4'h7);
    chk("ops_807f", {a_val, b_val}, 16'h807F);
    run_cmp("gt", 4'h0, 4'h0, 4'h0, 3'b001);
    load(1, 4'h0); load(2, 4'h1); load(3, 4'h0);
    chk("ops_0001", {a_val, b_val}, 16'h0001);
    run_cmp("lt", 4'h0, 4'h0, 4'h0, 3'b100);

    // reset in RUN cycle 4 aborts with no done
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_ctl", {busy, done}, 2'b00);
    chk("abort_ops", {a_val, b_val}, 16'h0000);
    chk("abort_lge", {lout, eout, gout}, 3'b010);
    ok = 1'b1;
    repeat (8) begin tick(); ok = ok & ~done & ~busy; end
    chk("abort_no_done", ok, 1'b1);

    // start coincides with pb[3] load: b=0x90 used by the compare
    run_cmp("coinc", 4'b1000, 4'h0, 4'h9, 3'b100);
    chk("coinc_b", b_val, 8'h90);

    // load attempt in RUN discarded
    load(0, 4'h0); load(1, 4'h1); load(2, 4'h0); load(3, 4'h1);
    chk("ops_1010", {a_val, b_val}, 16'h1010);
    run_cmp("runld", 4'h0, 4'b0001, 4'hF, 3'b010);
    chk("runld_a", a_val, 8'h10);

    // button mode: held pb[1] gives exactly one load on the 3rd edge
    pb_s = 4'b0010; y_s = 4'h3;
    tick(); chk("sync_e1", a_val_s, 8'h00);
    tick(); chk("sync_e2", a_val_s, 8'h00);
    tick(); chk("sync_e3", a_val_s, 8'h30);
    y_s = 4'h7;
    repeat (17) tick();
    chk("sync_once", a_val_s, 8'h30);
    pb_s = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
